// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory fetch arbiter: FSM states,
// RV32IC length decode constant and instruction length encoding.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } imem_arb_state_t;

  typedef enum logic {
    LEN_16 = 1'b0,
    LEN_32 = 1'b1
  } instr_len_t;

  // byte0[1:0] == 2'b11 marks a full-width 32-bit instruction
  localparam logic [1:0] OPC_32B = 2'b11;

endpackage

// File: rtl/imem_fetch_arbiter.sv
// Sole master of a byte-wide instruction memory: interleaves loader byte writes
// with byte-sequenced RV32IC instruction fetches (16- or 32-bit per request).
module imem_fetch_arbiter
  import imem_pkg::*;
#(
  parameter int AW             = 8,
  parameter int MAX_LOAD_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [AW-1:0]   load_addr,
  input  logic [7:0]      load_data,
  output logic            load_ready,
  input  logic            fetch_req,
  input  logic [AW-1:0]   fetch_pc,
  input  logic            fetch_flush,
  output logic            fetch_valid,
  output logic [31:0]     fetch_instr,
  output logic            fetch_len,
  output logic            busy,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic            mem_oe,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output imem_arb_state_t dbg_state
);

  localparam int BW = $clog2(MAX_LOAD_BURST + 1);

  imem_arb_state_t state, state_nxt;
  logic [AW-1:0]   base;
  logic [1:0]      cnt;
  logic [BW-1:0]   burst_cnt;
  logic [31:0]     instr_buf;
  logic            load_grant;
  logic            fetch_grant;
  logic            is_32b;
  instr_len_t      len;

  // Handshakes: a load beat transfers in any cycle with load_valid && load_ready
  // (ready is combinational, IDLE only); a fetch request is held with its pc
  // until the single-cycle fetch_valid pulse or until fetch_flush abandons it.
  // Loads win in IDLE until MAX_LOAD_BURST beats have starved a pending fetch.
  assign load_grant  = reset && (state == IDLE) && load_valid &&
                       !(fetch_req && (burst_cnt == BW'(MAX_LOAD_BURST)));
  assign fetch_grant = (state == IDLE) && !load_grant && fetch_req && !fetch_flush;

  assign is_32b = (instr_buf[1:0] == OPC_32B);
  assign len    = is_32b ? LEN_32 : LEN_16;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_grant) state_nxt = FETCH;
      FETCH: begin
        if (fetch_flush) state_nxt = IDLE;
        // byte0 was captured one edge earlier, so its length bits are valid at cnt==1
        else if ((cnt == 2'd1 && !is_32b) || cnt == 2'd3) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base      <= '0;
      cnt       <= '0;
      burst_cnt <= '0;
      instr_buf <= '0;
    end else begin
      state <= state_nxt;
      if (!fetch_req)       burst_cnt <= '0;
      else if (load_grant)  burst_cnt <= burst_cnt + BW'(1);
      else if (fetch_grant) burst_cnt <= '0;
      if (fetch_grant) begin
        base <= fetch_pc;
        cnt  <= '0;
      end else if (state == FETCH) begin
        instr_buf[{cnt, 3'b000} +: 8] <= mem_rdata;
        cnt <= cnt + 2'd1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_wdata = '0;
    if (load_grant) begin
      mem_addr  = load_addr;
      mem_we    = 1'b1;
      mem_wdata = load_data;
    end else if (state == FETCH) begin
      mem_oe   = 1'b1;
      mem_addr = base + AW'(cnt);
    end
  end

  assign load_ready  = load_grant;
  assign fetch_valid = (state == DONE) && !fetch_flush;
  assign fetch_len   = fetch_valid && (len == LEN_32);
  assign fetch_instr = !fetch_valid ? 32'h0 :
                       is_32b ? instr_buf : {16'h0, instr_buf[15:0]};
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

  fetch_req_held_a: assert property (@(posedge clk) disable iff (!reset)
    (state == FETCH && !fetch_flush) |-> fetch_req);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a byte memory model, an expected
// instruction queue checked on every fetch_valid, and an address trace.
module tb_imem_fetch_arbiter;
  import imem_pkg::*;

  logic            clk;
  logic            reset;
  logic            load_valid;
  logic [7:0]      load_addr;
  logic [7:0]      load_data;
  logic            load_ready;
  logic            fetch_req;
  logic [7:0]      fetch_pc;
  logic            fetch_flush;
  logic            fetch_valid;
  logic [31:0]     fetch_instr;
  logic            fetch_len;
  logic            busy;
  logic [7:0]      mem_addr;
  logic            mem_we;
  logic            mem_oe;
  logic [7:0]      mem_wdata;
  logic [7:0]      mem_rdata;
  imem_arb_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];    // {len, instr}
  logic [7:0]  addr_log[$];
  logic [7:0]  mem[256];

  imem_fetch_arbiter #(.AW(8), .MAX_LOAD_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_flush(fetch_flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_len(fetch_len),
    .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // byte memory model: write commits at the edge, read is combinational
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard and monitors
  always @(negedge clk) begin
    check("we_oe_exclusive", {63'h0, mem_we & mem_oe}, 64'h0);
    if (mem_oe) addr_log.push_back(mem_addr);
    if (fetch_valid) begin
      if (exp_q.size() == 0) check("valid_without_request", {63'h0, fetch_valid}, 64'h0);
      else check("instr_len", {31'h0, fetch_len, fetch_instr}, {31'h0, exp_q.pop_front()});
    end
  end

  // driver tasks (called at posedge+1)
  task automatic load_bytes(input logic [7:0] base, input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_addr  = base + 8'(i);
      load_data  = bytes[8*i +: 8];
      @(negedge clk);
      check("load_ready", {63'h0, load_ready}, 64'h1);
      check("load_we", {63'h0, mem_we}, 64'h1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [7:0] pc, input logic [32:0] exp, input int lat);
    int n;
    bit got;
    n = 0;
    got = 0;
    exp_q.push_back(exp);
    addr_log.delete();
    fetch_req = 1'b1;
    fetch_pc  = pc;
    while (n < 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (fetch_valid) got = 1;
    end
    fetch_req = 1'b0;
    check("fetch_timeout", {63'h0, got}, 64'h1);
    check("fetch_latency", 64'(n), 64'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int  n_ready;
    int  n_busy_ready;
    bit  got;
    bit  r;

    reset = 1'b0; load_valid = 1'b1; load_addr = 8'h33; load_data = 8'hAA;
    fetch_req = 1'b0; fetch_pc = 8'h00; fetch_flush = 1'b0;
    #12;
    check("reset_outputs",
          {26'h0, load_ready, fetch_valid, fetch_instr, fetch_len, busy,
           mem_addr, mem_we, mem_oe, mem_wdata},
          64'h0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    load_valid = 1'b0;
    @(posedge clk); #1;

    // 1: 32-bit fetch
    load_bytes(8'h10, 32'h0000_0513, 4);
    do_fetch(8'h10, {1'b1, 32'h0000_0513}, 5);

    // 2: 16-bit fetch touches only two addresses
    load_bytes(8'h20, 32'h0000_4501, 2);
    do_fetch(8'h20, {1'b0, 32'h0000_4501}, 3);
    check("c16_addr_count", 64'(addr_log.size()), 64'd2);
    if (addr_log.size() == 2) begin
      check("c16_addr0", 64'(addr_log[0]), 64'h20);
      check("c16_addr1", 64'(addr_log[1]), 64'h21);
    end

    // 3: address wrap across 0xFF
    load_bytes(8'hFE, 32'h0010_0093, 4);
    do_fetch(8'hFE, {1'b1, 32'h0010_0093}, 5);
    check("wrap_addr_count", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", 64'(addr_log[0]), 64'hFE);
      check("wrap_addr1", 64'(addr_log[1]), 64'hFF);
      check("wrap_addr2", 64'(addr_log[2]), 64'h00);
      check("wrap_addr3", 64'(addr_log[3]), 64'h01);
    end

    // 4: load burst starving a pending fetch
    exp_q.push_back({1'b1, 32'h0000_0513});
    fetch_req  = 1'b1;
    fetch_pc   = 8'h10;
    load_valid = 1'b1;
    load_addr  = 8'h40;
    load_data  = 8'($urandom_range(0, 255));
    n_ready = 0;
    n_busy_ready = 0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fetch_valid) begin
        got = 1;
        fetch_req = 1'b0;
        break;
      end
      r = load_ready;
      if (r && !busy) n_ready++;
      if (r && busy) n_busy_ready++;
      @(posedge clk); #1;
      if (r) begin
        load_addr = load_addr + 8'd1;
        load_data = 8'($urandom_range(0, 255));
      end
    end
    check("burst_fetch_done", {63'h0, got}, 64'h1);
    check("burst_load_beats", 64'(n_ready), 64'd4);
    check("burst_ready_while_busy", 64'(n_busy_ready), 64'd0);
    @(posedge clk); #1;
    check("burst_resume_ready", {63'h0, load_ready}, 64'h1);
    @(posedge clk); #1;
    load_valid = 1'b0;

    // 5: flush in the second FETCH cycle, then a flushed IDLE still loads
    fetch_req = 1'b1;
    fetch_pc  = 8'h10;
    @(posedge clk); #1;
    check("flush_busy_before", {63'h0, busy}, 64'h1);
    @(posedge clk); #1;
    fetch_flush = 1'b1;
    @(negedge clk);
    check("flush_no_valid", {63'h0, fetch_valid}, 64'h0);
    @(posedge clk); #1;
    check("flush_to_idle", 64'(dbg_state), 64'(IDLE));
    load_valid = 1'b1;
    load_addr  = 8'h50;
    load_data  = 8'h5A;
    #1;
    check("flush_idle_load_ready", {63'h0, load_ready}, 64'h1);
    @(posedge clk); #1;
    check("flush_blocks_grant", {63'h0, busy}, 64'h0);
    load_valid  = 1'b0;
    fetch_flush = 1'b0;
    fetch_req   = 1'b0;
    @(posedge clk); #1;
    do_fetch(8'h20, {1'b0, 32'h0000_4501}, 3);

    // 6: asynchronous reset mid-FETCH
    fetch_req = 1'b1;
    fetch_pc  = 8'h10;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_reset_oe", {63'h0, mem_oe}, 64'h1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs",
          {26'h0, load_ready, fetch_valid, fetch_instr, fetch_len, busy,
           mem_addr, mem_we, mem_oe, mem_wdata},
          64'h0);
    check("async_reset_state", 64'(dbg_state), 64'(IDLE));
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_idle", {63'h0, busy}, 64'h0);
    do_fetch(8'hFE, {1'b1, 32'h0010_0093}, 5);

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
